// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan sequencer.
//   NUM_ROWS / NUM_COLS : matrix geometry (4x4)
//   key_idx_t           : key index, row*4+col
//   key_evt_t           : FIFO event word, [4] release flag, [3:0] key index
//   key_cand_t          : key index plus a valid bit; KEY_NONE means no key
//   scan_state_t        : scanner FSM states
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_idx_t;
    typedef logic [4:0] key_evt_t;

    typedef struct packed {
        logic     valid;
        key_idx_t idx;
    } key_cand_t;

    // The index is forced to zero so that "no key" compares equal regardless of history.
    localparam key_cand_t KEY_NONE = '{valid: 1'b0, idx: 4'd0};

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EVAL
    } scan_state_t;

    function automatic logic [4:0] key_popcount(input logic [NUM_KEYS-1:0] bits);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {4'b0000, bits[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic key_idx_t key_lowest(input logic [NUM_KEYS-1:0] bits);
        key_idx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = key_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// First-word fall-through event FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i (dropped when full unless a pop happens in the same cycle)
//   push_data_i  : event word
//   ovf_clr_i    : clears overflow_o; a drop in the same cycle keeps it set
//   overflow_o   : sticky, an event was dropped
//   pop_i        : consume head (ignored when empty)
//   valid_o      : FIFO not empty
//   head_o       : oldest entry, zero when empty
module keypad_evt_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ovf_clr_i,
    output logic             overflow_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;

    logic full;
    logic pop_ok;
    logic push_ok;

    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
    assign push_ok = push_i && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AW + 1)'(1);
            end
            if (push_i && full && !pop_ok) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage carries no reset; valid_o gates its contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o    = (count_q != '0);
    assign head_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_scan_sequencer.sv
// 4x4 matrix keypad scanner with full-scan debounce and an event FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : scan enable, 0 parks the scanner in IDLE
//   col_n      : active-low columns, asynchronous, 2-flop synchronized
//   row_n      : active-low row strobes, at most one low
//   key_code   : FIFO head, [3:0] row*4+col, [4] release flag
//   key_valid  : FIFO not empty;  key_ready : consumer accepts head
//   ovf_clr    : clear overflow;  overflow  : sticky dropped-event flag
// Build option: KEYPAD_RELEASE_EVT_EN defined -> accepted releases push {1'b1, key}.
module keypad_scan_sequencer
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [4:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    input  logic       ovf_clr,
    output logic       overflow
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

    logic [NUM_COLS-1:0] col_meta_q;
    logic [NUM_COLS-1:0] col_sync_q;
    logic [NUM_COLS-1:0] cols;

    scan_state_t         state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] scan_buf_q, scan_buf_d;
    key_cand_t           prev_q, prev_d;
    key_cand_t           rep_q, rep_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;

    logic [4:0]          scan_pop;
    key_cand_t           cand;
    logic [DEB_W-1:0]    deb_next;
    logic                push;
    key_evt_t            push_data;

    assign cols = ~col_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
            state_q    <= IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            scan_buf_q <= '0;
            prev_q     <= KEY_NONE;
            rep_q      <= KEY_NONE;
            deb_cnt_q  <= '0;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            scan_buf_q <= scan_buf_d;
            prev_q     <= prev_d;
            rep_q      <= rep_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    // Classification of the completed scan.
    always_comb begin
        scan_pop = key_popcount(scan_buf_q);
        cand     = KEY_NONE;
        if (scan_pop == 5'd1) begin
            cand.valid = 1'b1;
            cand.idx   = key_lowest(scan_buf_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        scan_buf_d = scan_buf_q;
        prev_d     = prev_q;
        rep_d      = rep_q;
        deb_cnt_d  = deb_cnt_q;
        deb_next   = '0;
        push       = 1'b0;
        push_data  = '0;

        case (state_q)
            IDLE: begin
                if (ena) begin
                    state_d = DRIVE;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                scan_buf_d[{row_q, 2'b00} +: NUM_COLS] = cols;
                if (row_q == 2'd3) begin
                    state_d = EVAL;
                end else begin
                    state_d = DRIVE;
                    row_d   = row_q + 2'd1;
                end
            end
            EVAL: begin
                if (scan_pop > 5'd1) begin
                    // Ghosting: distrust this scan entirely, restart the stability count.
                    deb_cnt_d = '0;
                end else begin
                    if (cand == prev_q) begin
                        deb_next = (deb_cnt_q == DEB_MAX) ? DEB_MAX : deb_cnt_q + DEB_W'(1);
                    end else begin
                        prev_d   = cand;
                        deb_next = DEB_W'(1);
                    end
                    deb_cnt_d = deb_next;
                    if ((deb_next == DEB_MAX) && (cand != rep_q)) begin
                        rep_d = cand;
                        if (cand.valid) begin
                            push      = 1'b1;
                            push_data = {1'b0, cand.idx};
                        end
`ifdef KEYPAD_RELEASE_EVT_EN
                        if (!cand.valid) begin
                            push      = 1'b1;
                            push_data = {1'b1, rep_q.idx};
                        end
`endif
                    end
                end
                state_d = DRIVE;
                row_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disabling abandons the scan in progress; debounce state and FIFO are kept.
        if (!ena) begin
            state_d    = IDLE;
            row_d      = '0;
            cnt_d      = '0;
            scan_buf_d = '0;
        end
    end

    always_comb begin
        row_n = 4'hF;
        if ((state_q == DRIVE) || (state_q == SAMPLE)) begin
            row_n = ~(4'b0001 << row_q);
        end
    end

    keypad_evt_fifo #(
        .WIDTH (5),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .ovf_clr_i   (ovf_clr),
        .overflow_o  (overflow),
        .pop_i       (key_valid && key_ready),
        .valid_o     (key_valid),
        .head_o      (key_code)
    );

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
`timescale 1ns/1ps
module tb_keypad_scan_sequencer;

    localparam int DEB   = 2;
    localparam int DEPTH = 4;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       key_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] key_code;
    logic       key_valid;
    logic       overflow;

    logic [15:0] pressed = 16'h0;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: never ready, 1: always ready, 2: random

    // Reference model: expected FIFO contents as a queue, debounce as scan-level counters.
    int exp_q[$];
    int got_q[$];
    int m_prev = -1;
    int m_cnt  = 0;
    int m_rep  = -1;
    bit m_ovf  = 1'b0;
    logic [15:0] prev_keys = 16'h0;
    bit have_prev = 1'b0;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          evt;    // -1: none expected
    } seg_t;

    always #5 clk = ~clk;

    keypad_scan_sequencer #(
        .CLK_DIV        (4),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow)
    );

    // Keypad matrix: a pressed key connects its row strobe to its column.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && pressed[r*4+c]) begin
                    col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input int code);
        if (exp_q.size() < DEPTH) exp_q.push_back(code);
        else m_ovf = 1'b1;
    endtask

    task automatic model_eval(input logic [15:0] k);
        int n;
        int cand;
        n = $countones(k);
        if (n >= 2) begin
            m_cnt = 0;
            return;
        end
        cand = -1;
        for (int i = 0; i < 16; i++) if (k[i]) cand = i;
        if (cand == m_prev) begin
            if (m_cnt < DEB) m_cnt++;
        end else begin
            m_prev = cand;
            m_cnt  = 1;
        end
        if (m_cnt == DEB && cand != m_rep) begin
            if (cand >= 0) model_push(cand);
            else if (REL) model_push(16 + m_rep);
            m_rep = cand;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = -1; m_cnt = 0; m_rep = -1; m_ovf = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic wait_row0(output bit ok);
        logic [3:0] last;
        last = row_n;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (row_n == 4'hE && last == 4'hF) begin
                ok = 1'b1;
                break;
            end
            last = row_n;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL row0_timeout got row_n %0h want scan start", row_n);
        end
    endtask

    // One full scan with keys held; the previous scan is scored at this scan's start.
    task automatic scan(input logic [15:0] k);
        bit ok;
        wait_row0(ok);
        if (have_prev) begin
            model_eval(prev_keys);
            chk("key_valid", int'(key_valid), int'(exp_q.size() > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
        end
        pressed   = k;
        prev_keys = k;
        have_prev = 1'b1;
    endtask

    task automatic clear_ovf();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_clr", int'(overflow), 0);
    endtask

    // Consumer: decides ready at the negedge, so a pop seen here happens at the next posedge.
    always @(negedge clk) begin : consumer
        bit r;
        int e;
        case (ready_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = 1'($urandom_range(0, 1));
        endcase
        if (rst_n && key_valid && r) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            $display("POP code=%02h expect=%02h", key_code, e);
            chk("pop_code", int'(key_code), e);
            got_q.push_back(int'(key_code));
        end
        key_ready = r;
    end

    initial begin
        seg_t tbl[13];
        int   exp_list[$];
        bit   ok;
        logic [15:0] k;

        tbl[0]  = '{16'h0000, 2, -1};
        tbl[1]  = '{16'h0200, 4, 'h09};
        tbl[2]  = '{16'h0000, 2, REL ? 'h19 : -1};
        tbl[3]  = '{16'h0040, 1, -1};
        tbl[4]  = '{16'h0000, 1, -1};
        tbl[5]  = '{16'h0040, 1, -1};
        tbl[6]  = '{16'h0000, 1, -1};
        tbl[7]  = '{16'h0040, 1, -1};
        tbl[8]  = '{16'h0000, 1, -1};
        tbl[9]  = '{16'h0040, 2, 'h06};
        tbl[10] = '{16'h0021, 3, -1};
        tbl[11] = '{16'h0020, 2, 'h05};
        tbl[12] = '{16'h0000, 2, REL ? 'h15 : -1};

        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_n", int'(row_n), 'hF);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_code", int'(key_code), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: debounce, no auto-repeat, toggling, ghosting, key-to-key.
        ready_mode = 1;
        got_q.delete();
        foreach (tbl[i]) begin
            $display("SEG %0d keys=%04h scans=%0d", i, tbl[i].keys, tbl[i].scans);
            for (int s = 0; s < tbl[i].scans; s++) scan(tbl[i].keys);
            if (tbl[i].evt >= 0) exp_list.push_back(tbl[i].evt);
        end
        scan(16'h0000);
        scan(16'h0000);
        chk("table_evt_count", got_q.size(), exp_list.size());
        foreach (exp_list[i]) chk("table_evt", (i < got_q.size()) ? got_q[i] : -1, exp_list[i]);

        // Overflow: five key-to-key presses with consumer stalled.
        ready_mode = 0;
        got_q.delete();
        foreach (tbl[i]) begin end
        scan(16'h0002); scan(16'h0002);
        scan(16'h0004); scan(16'h0004);
        scan(16'h0008); scan(16'h0008);
        scan(16'h0010); scan(16'h0010);
        scan(16'h0080); scan(16'h0080);
        scan(16'h0080);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_full_valid", int'(key_valid), 1);
        ready_mode = 1;
        scan(16'h0080);
        scan(16'h0080);
        chk("drain_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_order", (i < got_q.size()) ? got_q[i] : -1, i + 1);
        chk("ovf_sticky", int'(overflow), 1);
        clear_ovf();
        scan(16'h0000); scan(16'h0000); scan(16'h0000);

        // Randomized segments against the model.
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int kind;
            int reps;
            kind = $urandom_range(0, 3);
            reps = $urandom_range(1, 3);
            k = 16'h0;
            if (kind == 1 || kind == 2) begin
                k[$urandom_range(0, 15)] = 1'b1;
            end else if (kind == 3) begin
                int a;
                int b;
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k[a] = 1'b1;
                k[b] = 1'b1;
            end
            $display("RND %0d keys=%04h scans=%0d", n, k, reps);
            for (int s = 0; s < reps; s++) scan(k);
        end
        ready_mode = 1;
        scan(prev_keys); scan(prev_keys); scan(prev_keys);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_valid", int'(key_valid), 0);
        clear_ovf();

        // Enable drop mid-scan, then release of key 9 after re-enable.
        ready_mode = 0;
        scan(16'h0000); scan(16'h0000);
        scan(16'h0200); scan(16'h0200); scan(16'h0200);
        repeat (6) @(negedge clk);
        ena = 1'b0;
        @(posedge clk);
        #1;
        chk("ena_row_n", int'(row_n), 'hF);
        have_prev = 1'b0;
        ready_mode = 1;
        got_q.delete();
        repeat (10) @(negedge clk);
        chk("ena_idle_row_n", int'(row_n), 'hF);
        chk("ena_drain_valid", int'(key_valid), 0);
        chk("ena_drain_code", got_q.size() > 0 ? got_q[0] : -1, 'h09);
        got_q.delete();
        ena = 1'b1;
        scan(16'h0000); scan(16'h0000); scan(16'h0000); scan(16'h0000);
        chk("rel_count", got_q.size(), REL ? 1 : 0);
        chk("rel_code", got_q.size() > 0 ? got_q[0] : 0, REL ? 'h19 : 0);

        // Asynchronous reset in the middle of a row drive with FIFO full and overflow set.
        ready_mode = 0;
        scan(16'h0008); scan(16'h0008);
        scan(16'h0400); scan(16'h0400);
        scan(16'h0800); scan(16'h0800);
        scan(16'h1000); scan(16'h1000);
        scan(16'h2000); scan(16'h2000);
        scan(16'h2000);
        chk("pre_rst_ovf", int'(overflow), 1);
        wait_row0(ok);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_row_n", int'(row_n), 'hF);
        chk("async_key_valid", int'(key_valid), 0);
        chk("async_overflow", int'(overflow), 0);
        chk("async_key_code", int'(key_code), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        scan(16'h0000); scan(16'h0000); scan(16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
